// File: rtl/muldiv_pkg.sv
// Shared op encodings and state type for the iterative multiply/divide unit.
// The ALU decoder imports the same MD_* constants.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// with start/busy/done handshake, cancel and defined divide-by-zero result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};

  md_state_e        state_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r, done_r;
  logic             is_div_r, res_sign_r, rem_sign_r, dbz_r;
  logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opnd_r, a_raw_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             a_neg_s, b_neg_s, accept_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [WIDTH-1:0] acc_hi_nxt_s, acc_lo_nxt_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s, hi_res_s, lo_res_s;

  assign accept_s = start & ~cancel;
  assign a_neg_s  = md_is_signed(op) & a[WIDTH-1];
  assign b_neg_s  = md_is_signed(op) & b[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_abs_a (.neg(a_neg_s), .x(a), .y(a_mag_s));
  muldiv_negate #(.W(WIDTH)) u_abs_b (.neg(b_neg_s), .x(b), .y(b_mag_s));

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg(res_sign_r), .x({acc_hi_r, acc_lo_r}), .y(prod_fix_s));
  muldiv_negate #(.W(WIDTH)) u_fix_quo (.neg(res_sign_r), .x(acc_lo_r), .y(quo_fix_s));
  muldiv_negate #(.W(WIDTH)) u_fix_rem (.neg(rem_sign_r), .x(acc_hi_r), .y(rem_fix_s));

  // One iteration step; the W+1-bit trial value is the shifted partial remainder.
  always_comb begin
    mul_sum_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s   = div_shift_s - {1'b0, opnd_r};
    acc_hi_nxt_s = acc_hi_r;
    acc_lo_nxt_s = acc_lo_r;
    if (is_div_r) begin
      // A set top bit of the difference is the borrow: restore.
      if (div_diff_s[WIDTH]) begin
        acc_hi_nxt_s = div_shift_s[WIDTH-1:0];
        acc_lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_hi_nxt_s = div_diff_s[WIDTH-1:0];
        acc_lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_hi_nxt_s = mul_sum_s[WIDTH:1];
      acc_lo_nxt_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Final result selection, including the divide-by-zero override.
  always_comb begin
    hi_res_s = rem_fix_s;
    lo_res_s = quo_fix_s;
    if (!is_div_r) begin
      hi_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_res_s = prod_fix_s[WIDTH-1:0];
    end else if (dbz_r) begin
      hi_res_s = a_raw_r;
      lo_res_s = ONES_W;
    end else begin
      hi_res_s = rem_fix_s;
      lo_res_s = quo_fix_s;
    end
  end

  // Control FSM: state, iteration counter and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= CALC;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b1;
          end
        end
        CALC: begin
          if (cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == LAST_ITER) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= ~cancel;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand latch, shared accumulator pair and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_r   <= 1'b0;
      res_sign_r <= 1'b0;
      rem_sign_r <= 1'b0;
      dbz_r      <= 1'b0;
      acc_hi_r   <= ZERO_W;
      acc_lo_r   <= ZERO_W;
      opnd_r     <= ZERO_W;
      a_raw_r    <= ZERO_W;
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            is_div_r   <= md_is_div(op);
            res_sign_r <= a_neg_s ^ b_neg_s;
            rem_sign_r <= a_neg_s;
            dbz_r      <= (b == ZERO_W);
            a_raw_r    <= a;
            acc_hi_r   <= ZERO_W;
            // Divide shifts the dividend out of lo; multiply shifts the multiplier.
            acc_lo_r   <= md_is_div(op) ? a_mag_s : b_mag_s;
            opnd_r     <= md_is_div(op) ? b_mag_s : a_mag_s;
          end
        end
        CALC: begin
          if (!cancel) begin
            acc_hi_r <= acc_hi_nxt_s;
            acc_lo_r <= acc_lo_nxt_s;
          end
        end
        FIX: begin
          if (!cancel) begin
            hi_r <= hi_res_s;
            lo_r <= lo_res_s;
          end
        end
        default: begin
          acc_hi_r <= acc_hi_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at WIDTH=32 plus handshake corner cases.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;
  int lat;
  int seen_done;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request for one cycle (or keep it held) and check busy after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold, input string name);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    check({name, "_busy"}, {63'd0, busy}, 64'd1);
    if (!hold) start = 1'b0;
  endtask

  // Count edges after acceptance until done; while k < hold, scramble the inputs.
  task automatic wait_done(input int hold, output int l);
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        l = k;
        break;
      end
      if (k < hold) begin
        a = ~a; b = b + 32'd3; op = MD_DIVU;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[10] = '{MD_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
    vecs[11] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

    // Reset values while rst is held low.
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
      wait_done(0, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      check($sformatf("vec%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_single", i), {63'd0, done}, 64'd0);
    end

    // Cancel 10 cycles into a MULTU: no done, previous 100/7 result kept.
    issue(MD_MULTU, 32'd3, 32'd5, 1'b0, "cancel_issue");
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("cancel_no_done", 64'(seen_done), 64'd0);
    check("cancel_hi", {32'd0, hi}, 64'd2);
    check("cancel_lo", {32'd0, lo}, 64'd14);

    // start and cancel together in IDLE: dropped.
    @(negedge clk);
    op = MD_MULTU; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", {63'd0, busy}, 64'd0);

    // start held (with changing operands) through CALC is not re-accepted.
    issue(MD_MULTU, 32'd3, 32'd5, 1'b1, "held_issue");
    wait_done(20, lat);
    check("held_latency", 64'(lat), 64'd33);
    check("held_hi", {32'd0, hi}, 64'd0);
    check("held_lo", {32'd0, lo}, 64'd15);

    // Back-to-back: new start accepted in the done cycle.
    op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done_low", {63'd0, done}, 64'd0);
    wait_done(0, lat);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_lo", {32'd0, lo}, 64'd42);

    // Asynchronous reset mid-operation clears outputs immediately.
    issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, "rst_mid_issue");
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_done", {63'd0, done}, 64'd0);
    check("rstmid_hi", {32'd0, hi}, 64'd0);
    check("rstmid_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, "post_rst_issue");
    wait_done(0, lat);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_hi", {32'd0, hi}, 64'd1);
    check("post_rst_lo", {32'd0, lo}, 64'd333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit of parametrised width, one bit per cycle. It replaces the ALU's ad-hoc divider hookup with a clean start/busy/done handshake, a cancel path for pipeline flush, and defined divide-by-zero behaviour. It sits beside the EX-stage ALU: the ALU decodes the mult/div ops and asserts `start`, and the hazard unit stalls on `busy`. `hi`/`lo` feed the HI/LO register write port.

## Interface
- `WIDTH`, 32, operand width; even, ≥4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `cancel`  in  1  flush; aborts any in-flight op.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `hi`  out  WIDTH  MULT: product upper half; DIV: remainder.
- `lo`  out  WIDTH  MULT: product lower half; DIV: quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on `start && !cancel`:
  - latch op and operand magnitudes (signed ops take |a|, |b|);
  - latch the result-sign flags: product/quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1]; both 0 for unsigned ops;
  - clear the iteration counter; go to CALC.
- CALC, multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- CALC exits to FIX after exactly WIDTH iterations. The counter is $clog2(WIDTH)+1 bits.
- FIX:
  - conditionally negate each result by its sign flag;
  - register `hi`/`lo`; pulse `done`; go to IDLE.
- Divide by zero: no early exit, same latency. Result is `lo` = all ones, `hi` = dividend (`a` as given, for both signed and unsigned).
- Signed overflow, MIN / -1: `lo` = MIN, `hi` = 0. This falls out of the magnitude path naturally and needs no special case.
- `start` in CALC or FIX is ignored; there is no queueing.
- `cancel` in CALC or FIX: go to IDLE at the next edge. No `done`; `hi`/`lo` unchanged.
- `cancel` and `start` together in IDLE: the start is dropped.
- `hi`/`lo` hold the last completed result until the next FIX.

## Timing
- Reset (async, `rst`=0): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and accumulators cleared.
- Start accepted at edge E0 → `busy`=1 from E0 onward.
- CALC occupies edges E1..E_WIDTH.
- FIX at E_(WIDTH+1): `done`=1 and `busy`=0 for the following cycle. Latency is WIDTH+1 cycles (33 at default).
- A new `start` is accepted at E_(WIDTH+2), the same cycle `done` is high. The back-to-back issue interval is WIDTH+2 cycles.
- `done` never rises without a matching accepted start. It is never high for two consecutive cycles.
- Reset mid-operation: immediate return to reset values; the in-flight result is lost.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding constants MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum IDLE/CALC/FIX.
- The ALU imports the same op constants.
- One natural sub-module, `muldiv_negate`: combinational, parametrised width, conditional two's-complement negate (`neg ? ~x+1 : x`).
  - Instantiated for the operand magnitudes and for the result fix-up.
- The datapath shares one accumulator pair between mul and div.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 cycles: `done`, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV a=-7 b=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
- DIV a=0x80000000 b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=7 b=0 → `lo`=0xFFFFFFFF, `hi`=7, latency still 33.
- DIVU 100/7 completes (`hi`=2, `lo`=14); then:
  - issue MULTU, assert `cancel` 10 cycles in → no `done`, `busy`=0 next cycle, `hi`/`lo` still 2/14;
  - a `start` held through CALC is not re-accepted;
  - assert `rst` mid-op → all outputs 0 immediately.
